// File: rtl/seq_mult_nxn.sv
// -----------------------------------------------------------------------------
// seq_mult_nxn
//
// Sequential WIDTH x WIDTH unsigned multiplier. One 4x4 nibble partial
// product is formed per clock, shifted into place and added to a 2*WIDTH-bit
// accumulator. A start/ready/done handshake frames each operation.
//
// Latency: the start edge is E0. The next NIB*NIB edges are CALC edges. product
// and done update on edge E(NIB*NIB+1). ready is high again in the done cycle,
// so a new start may be issued then.
//
// Optional feature (macro SEQ_MULT_SIGNED_EN):
//   Adds the signed_op input, sampled with start. When it is 1, the operands
//   are two's complement. Their magnitudes are multiplied as usual, and the
//   result is negated on the way to product when the operand signs differ.
//   When the macro is undefined, the design is unsigned only and has no
//   signed_op port.
//
// Parameters:
//   WIDTH     operand width in bits; must be a multiple of 4 and >= 4
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request a new multiply; sampled only while ready=1
//   signed_op  (SEQ_MULT_SIGNED_EN only) treat operands as two's complement
//   dataa      multiplicand, captured on an accepted start
//   datab      multiplier, captured on an accepted start
//   ready      1 = idle and able to accept start
//   done       one-cycle pulse when product updates
//   product    registered result, held until the next done
// -----------------------------------------------------------------------------
module seq_mult_nxn #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic                 signed_op,
`endif
   input  logic [WIDTH-1:0]     dataa,
   input  logic [WIDTH-1:0]     datab,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned PW  = 2 * WIDTH;
   // Counter width; NIB=1 still needs a one-bit counter.
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("seq_mult_nxn: WIDTH must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    i_cnt;
   logic [CW-1:0]    j_cnt;

   // Operand values to latch on start: the raw operands, or their magnitudes
   // in the signed build.
   logic [WIDTH-1:0] load_a;
   logic [WIDTH-1:0] load_b;
   logic [PW-1:0]    result;

`ifdef SEQ_MULT_SIGNED_EN
   logic neg_q;
   logic neg_d;

   always_comb begin
      load_a = dataa;
      load_b = datab;
      neg_d  = 1'b0;
      if (signed_op) begin
         // Unary minus keeps WIDTH bits, so -2^(WIDTH-1) maps to its exact
         // unsigned magnitude 2^(WIDTH-1).
         if (dataa[WIDTH-1]) load_a = -dataa;
         if (datab[WIDTH-1]) load_b = -datab;
         neg_d = dataa[WIDTH-1] ^ datab[WIDTH-1];
      end
   end

   assign result = neg_q ? -acc : acc;
`else
   assign load_a = dataa;
   assign load_b = datab;
   assign result = acc;
`endif

   // Current nibble partial product, shifted to its weight 4*(i+j).
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [7:0]    pp;
   logic [CW:0]   nib_sum;
   logic [PW-1:0] pp_shift;

   always_comb begin
      a_nib    = a_q[{i_cnt, 2'b00} +: 4];
      b_nib    = b_q[{j_cnt, 2'b00} +: 4];
      pp       = 8'(a_nib) * 8'(b_nib);
      nib_sum  = {1'b0, i_cnt} + {1'b0, j_cnt};
      pp_shift = PW'(pp) << {nib_sum, 2'b00};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StIdle;
         ready   <= 1'b1;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         i_cnt   <= '0;
         j_cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= load_a;
                  b_q   <= load_b;
                  acc   <= '0;
                  i_cnt <= '0;
                  j_cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                  neg_q <= neg_d;
`endif
                  ready <= 1'b0;
                  state <= StCalc;
               end
            end

            StCalc: begin
               done <= 1'b0;
               acc  <= acc + pp_shift;
               if (i_cnt == LAST) begin
                  i_cnt <= '0;
                  if (j_cnt == LAST) begin
                     state <= StDone;
                  end else begin
                     j_cnt <= j_cnt + 1'b1;
                  end
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end

            StDone: begin
               product <= result;
               done    <= 1'b1;
               ready   <= 1'b1;
               state   <= StIdle;
            end

            default: begin
               state <= StIdle;
               ready <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
